// File: rtl/updown_count_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | updown_count_arbiter: round-robin shared up/down counter, one command   |
// | (direction + step count) per grant.                       Revision: 1.0 |
// +--------------------------------------------------------------------------+
module updown_count_arbiter #(
  parameter int WIDTH = 3,
  parameter int STEPW = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [1:0]       req_dir,
  input  logic [STEPW-1:0] req_steps0,
  input  logic [STEPW-1:0] req_steps1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_en,
  output logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             lim
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [STEPW-1:0] r_rem;
  logic             r_rr_last;
  logic             r_dir;
  logic             r_owner;
  logic [1:0]       r_done;
  logic             r_busy;
  logic             r_cnt_en;
  logic             r_mode;

  logic             w_win;
  logic             w_win_dir;
  logic [STEPW-1:0] w_win_steps;
  logic             w_at_lim;
  logic [WIDTH-1:0] w_next_count;

  // With both requesting, the one that did not win last time takes the grant.
  always_comb begin
    w_win = req[1];
    if (req == 2'b11) begin
      w_win = ~r_rr_last;
    end
  end

  assign w_win_dir   = w_win ? req_dir[1] : req_dir[0];
  assign w_win_steps = w_win ? req_steps1 : req_steps0;

  assign w_at_lim = r_dir ? (r_count == '0) : (r_count == C_MAX);

  always_comb begin
    w_next_count = r_dir ? (r_count - 1'b1) : (r_count + 1'b1);
    if ((SAT != 0) && w_at_lim) begin
      w_next_count = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_rr_last <= 1'b1;
      r_dir     <= 1'b0;
      r_owner   <= 1'b0;
      r_done    <= 2'b00;
      r_busy    <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_mode    <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner   <= w_win;
            r_dir     <= w_win_dir;
            r_rem     <= w_win_steps;
            r_rr_last <= w_win;
            r_busy    <= 1'b1;
            if (w_win_steps != '0) begin
              r_state  <= S_RUN;
              r_cnt_en <= 1'b1;
              r_mode   <= w_win_dir;
            end else begin
              r_state        <= S_DONE;
              r_done[w_win]  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_count <= w_next_count;
          r_rem   <= r_rem - 1'b1;
          if (r_rem == STEPW'(1)) begin
            r_state         <= S_DONE;
            r_cnt_en        <= 1'b0;
            r_mode          <= 1'b0;
            r_done[r_owner] <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_cnt_en <= 1'b0;
          r_mode   <= 1'b0;
        end
      endcase
    end
  end

  // Grant is combinational so a requester sees it in its request cycle.
  always_comb begin
    gnt = 2'b00;
    if ((r_state == S_IDLE) && (|req) && !clr) begin
      gnt = w_win ? 2'b10 : 2'b01;
    end
  end

  assign done   = r_done;
  assign busy   = r_busy;
  assign cnt_en = r_cnt_en;
  assign mode   = r_mode;
  assign count  = r_count;
  assign lim    = r_cnt_en & w_at_lim;

endmodule
`default_nettype wire

// File: tb/tb_updown_count_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_updown_count_arbiter: directed bench, wrapping and saturating DUTs.  |
// |                                                           Revision: 1.0 |
// +--------------------------------------------------------------------------+
module tb_updown_count_arbiter;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] req_a, req_b, dir;
  logic [3:0] s0, s1;

  logic [1:0] gnt_a, done_a, gnt_b, done_b;
  logic       busy_a, cnt_en_a, mode_a, lim_a;
  logic       busy_b, cnt_en_b, mode_b, lim_b;
  logic [2:0] count_a, count_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  updown_count_arbiter #(.WIDTH(3), .STEPW(4), .SAT(0)) u_wrap (
    .clk(clk), .clr(clr), .req(req_a), .req_dir(dir),
    .req_steps0(s0), .req_steps1(s1),
    .gnt(gnt_a), .done(done_a), .busy(busy_a), .cnt_en(cnt_en_a),
    .mode(mode_a), .count(count_a), .lim(lim_a)
  );

  updown_count_arbiter #(.WIDTH(3), .STEPW(4), .SAT(1)) u_sat (
    .clk(clk), .clr(clr), .req(req_b), .req_dir(dir),
    .req_steps0(s0), .req_steps1(s1),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .cnt_en(cnt_en_b),
    .mode(mode_b), .count(count_b), .lim(lim_b)
  );

  wire [10:0] w_obs_a = {gnt_a, done_a, busy_a, cnt_en_a, mode_a, count_a, lim_a};
  wire [10:0] w_obs_b = {gnt_b, done_b, busy_b, cnt_en_b, mode_b, count_b, lim_b};

  // Tuple layout: gnt, done, busy, cnt_en, mode, count, lim
  function automatic logic [10:0] ex(input logic [1:0] g, input logic [1:0] d,
                                     input logic b, input logic c, input logic m,
                                     input logic [2:0] n, input logic l);
    return {g, d, b, c, m, n, l};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; req_a = 2'b00; req_b = 2'b00; dir = 2'b00; s0 = 4'd0; s1 = 4'd0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("reset_a", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd0, 0));
    chk("reset_b", w_obs_b, ex(2'b00, 2'b00, 0, 0, 0, 3'd0, 0));
    clr = 1'b0;

    // Basic: requester 0 up 3 steps from 0 on both counters
    @(negedge clk); req_a = 2'b01; req_b = 2'b01; dir = 2'b00; s0 = 4'd3; #1;
    chk("t2_gnt", w_obs_a, ex(2'b01, 2'b00, 0, 0, 0, 3'd0, 0));
    @(negedge clk); req_a = 2'b00; req_b = 2'b00; #1;
    chk("t2_run1", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd0, 0));
    @(negedge clk); #1;
    chk("t2_run2", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd1, 0));
    @(negedge clk); #1;
    chk("t2_run3", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd2, 0));
    @(negedge clk); #1;
    chk("t2_done", w_obs_a, ex(2'b00, 2'b01, 1, 0, 0, 3'd3, 0));
    chk("t2_done_b", w_obs_b, ex(2'b00, 2'b01, 1, 0, 0, 3'd3, 0));
    @(negedge clk); #1;
    chk("t2_idle", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd3, 0));

    // Reset mid-run: requester 0 up 5, clear after two steps
    @(negedge clk); req_a = 2'b01; req_b = 2'b01; s0 = 4'd5; #1;
    chk("t1_gnt", w_obs_a, ex(2'b01, 2'b00, 0, 0, 0, 3'd3, 0));
    @(negedge clk); req_a = 2'b00; req_b = 2'b00; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t1_run", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd5, 0));
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; #1;
    chk("t1_clr", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd0, 0));
    chk("t1_clr_b", w_obs_b, ex(2'b00, 2'b00, 0, 0, 0, 3'd0, 0));
    @(negedge clk); #1;
    chk("t1_nodone", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd0, 0));

    // Arbitration: both request 1 step continuously; grants alternate 01,10,...
    req_a = 2'b11; req_b = 2'b11; dir = 2'b00; s0 = 4'd1; s1 = 4'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_gnt", w_obs_a, ex((k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 0, 0, 0, 3'(k), 0));
      @(negedge clk); #1;
      chk("t3_run", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'(k), 0));
      @(negedge clk); #1;
      chk("t3_done", w_obs_a, ex(2'b00, (k % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 0, 3'(k + 1), 0));
      @(negedge clk);
    end
    req_a = 2'b00; req_b = 2'b00; #1;
    chk("t3_idle", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd4, 0));

    // Bring both counters to 6
    @(negedge clk); req_a = 2'b01; req_b = 2'b01; s0 = 4'd2; #1;
    @(negedge clk); req_a = 2'b00; req_b = 2'b00;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_a", w_obs_a, ex(2'b00, 2'b01, 1, 0, 0, 3'd6, 0));
    chk("pre_b", w_obs_b, ex(2'b00, 2'b01, 1, 0, 0, 3'd6, 0));
    @(negedge clk);

    // Wrap: requester 1 up 3 steps from 6
    @(negedge clk); req_a = 2'b10; dir = 2'b00; s1 = 4'd3; #1;
    chk("t4_gnt", w_obs_a, ex(2'b10, 2'b00, 0, 0, 0, 3'd6, 0));
    @(negedge clk); req_a = 2'b00; #1;
    chk("t4_s6", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd6, 0));
    @(negedge clk); #1;
    chk("t4_s7_lim", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd7, 1));
    @(negedge clk); #1;
    chk("t4_s0", w_obs_a, ex(2'b00, 2'b00, 1, 1, 0, 3'd0, 0));
    @(negedge clk); #1;
    chk("t4_done", w_obs_a, ex(2'b00, 2'b10, 1, 0, 0, 3'd1, 0));
    @(negedge clk);

    // Wrap down: requester 0 down 2 steps from 1
    @(negedge clk); req_a = 2'b01; dir = 2'b01; s0 = 4'd2; #1;
    chk("t4d_gnt", w_obs_a, ex(2'b01, 2'b00, 0, 0, 0, 3'd1, 0));
    @(negedge clk); req_a = 2'b00; #1;
    chk("t4d_s1", w_obs_a, ex(2'b00, 2'b00, 1, 1, 1, 3'd1, 0));
    @(negedge clk); #1;
    chk("t4d_s0_lim", w_obs_a, ex(2'b00, 2'b00, 1, 1, 1, 3'd0, 1));
    @(negedge clk); #1;
    chk("t4d_done", w_obs_a, ex(2'b00, 2'b01, 1, 0, 0, 3'd7, 0));
    @(negedge clk);

    // Saturate: requester 0 up 4 steps from 6 on the clamping counter
    @(negedge clk); req_b = 2'b01; dir = 2'b00; s0 = 4'd4; #1;
    chk("t5_gnt", w_obs_b, ex(2'b01, 2'b00, 0, 0, 0, 3'd6, 0));
    @(negedge clk); req_b = 2'b00; #1;
    chk("t5_s6", w_obs_b, ex(2'b00, 2'b00, 1, 1, 0, 3'd6, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_clamp", w_obs_b, ex(2'b00, 2'b00, 1, 1, 0, 3'd7, 1));
    end
    @(negedge clk); #1;
    chk("t5_done", w_obs_b, ex(2'b00, 2'b01, 1, 0, 0, 3'd7, 0));
    @(negedge clk);

    // Zero steps: requester 1 with steps=0
    @(negedge clk); req_a = 2'b10; s1 = 4'd0; #1;
    chk("t6_gnt", w_obs_a, ex(2'b10, 2'b00, 0, 0, 0, 3'd7, 0));
    @(negedge clk); req_a = 2'b00; #1;
    chk("t6_done", w_obs_a, ex(2'b00, 2'b10, 1, 0, 0, 3'd7, 0));
    @(negedge clk); #1;
    chk("t6_idle", w_obs_a, ex(2'b00, 2'b00, 0, 0, 0, 3'd7, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
